// File: rtl/gp_dram_write_arbiter_if.sv
// Bundle of engine request ports and DRAM af/wdf write ports shared by the
// write arbiter. The arbiter takes the slave view; the engines and FIFOs
// (or a testbench standing in for them) take the master view.
interface gp_dram_write_arbiter_if #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
);
    logic                  LE_req,  FF_req,  CE_req;
    logic [ADDR_WIDTH-1:0] LE_addr, FF_addr, CE_addr;
    logic [DATA_WIDTH-1:0] LE_data, FF_data, CE_data;
    logic [MASK_WIDTH-1:0] LE_mask, FF_mask, CE_mask;
    logic                  LE_ack,  FF_ack,  CE_ack;

    logic                  af_full;
    logic                  wdf_full;
    logic                  af_wr_en;
    logic [ADDR_WIDTH-1:0] af_addr_din;
    logic                  wdf_wr_en;
    logic [DATA_WIDTH-1:0] wdf_din;
    logic [MASK_WIDTH-1:0] wdf_mask_din;
    logic                  busy;

    // Engines + FIFO status side
    modport master (
        output LE_req, FF_req, CE_req,
        output LE_addr, FF_addr, CE_addr,
        output LE_data, FF_data, CE_data,
        output LE_mask, FF_mask, CE_mask,
        input  LE_ack, FF_ack, CE_ack,
        output af_full, wdf_full,
        input  af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din, busy
    );

    // Arbiter side
    modport slave (
        input  LE_req, FF_req, CE_req,
        input  LE_addr, FF_addr, CE_addr,
        input  LE_data, FF_data, CE_data,
        input  LE_mask, FF_mask, CE_mask,
        output LE_ack, FF_ack, CE_ack,
        input  af_full, wdf_full,
        output af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din, busy
    );
endinterface

// File: rtl/gp_dram_write_arbiter.sv
// Round-robin arbiter sharing the DRAM write path (one af entry + two wdf
// beats per burst) among the line engine, frame filler and circle engine.
// Bursts are never interleaved; the grant is held until both beats land.
module gp_dram_write_arbiter #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst,
    gp_dram_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic [1:0] r_last,  w_last_nxt;

    logic [2:0] w_req;
    logic [1:0] w_start;
    logic [1:0] w_pick;
    logic       w_af_en;
    logic       w_wdf_en;

    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [MASK_WIDTH-1:0] w_sel_mask;
    logic [2:0]            w_ack;

    assign w_req = {bus.CE_req, bus.FF_req, bus.LE_req};

    // Round-robin pick: first requester found searching from (last+1) mod 3
    always_comb begin
        logic [2:0] v_idx;
        logic       v_found;
        w_start = (r_last >= 2'd2) ? 2'd0 : r_last + 2'd1;
        w_pick  = r_grant;
        v_found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v_idx = {1'b0, w_start} + 3'(k);
            if (v_idx >= 3'd3) v_idx = v_idx - 3'd3;
            if (!v_found && w_req[v_idx[1:0]]) begin
                w_pick  = v_idx[1:0];
                v_found = 1'b1;
            end
        end
    end

    // State, grant and last-served registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
            r_grant <= 2'd0;
            r_last  <= 2'd2;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state and write enables; full flags gate the beat combinationally.
    // Enables are forced low while rst is high so an abandoned burst never
    // pushes anything into the FIFOs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_af_en     = 1'b0;
        w_wdf_en    = 1'b0;
        case (r_state)
            ARB: begin
                if (|w_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = BEAT0;
                end
            end
            BEAT0: begin
                if (!bus.af_full && !bus.wdf_full) begin
                    w_af_en     = 1'b1;
                    w_wdf_en    = 1'b1;
                    w_state_nxt = BEAT1;
                end
            end
            BEAT1: begin
                if (!bus.wdf_full) begin
                    w_wdf_en    = 1'b1;
                    w_last_nxt  = r_grant;
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
        if (rst) begin
            w_af_en  = 1'b0;
            w_wdf_en = 1'b0;
        end
    end

    // Select the granted requester's address/data/mask
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_mask = '0;
        case (r_grant)
            2'd0: begin
                w_sel_addr = bus.LE_addr;
                w_sel_data = bus.LE_data;
                w_sel_mask = bus.LE_mask;
            end
            2'd1: begin
                w_sel_addr = bus.FF_addr;
                w_sel_data = bus.FF_data;
                w_sel_mask = bus.FF_mask;
            end
            2'd2: begin
                w_sel_addr = bus.CE_addr;
                w_sel_data = bus.CE_data;
                w_sel_mask = bus.CE_mask;
            end
            default: ;
        endcase
    end

    // Ack only the granted engine, and only on a beat actually written
    always_comb begin
        w_ack = 3'b000;
        if (w_wdf_en && r_grant <= 2'd2) w_ack[r_grant] = 1'b1;
    end

    assign bus.LE_ack       = w_ack[0];
    assign bus.FF_ack       = w_ack[1];
    assign bus.CE_ack       = w_ack[2];
    assign bus.af_wr_en     = w_af_en;
    assign bus.wdf_wr_en    = w_wdf_en;
    // Payload is zeroed when not pushed, for deterministic waveforms
    assign bus.af_addr_din  = w_af_en  ? w_sel_addr : '0;
    assign bus.wdf_din      = w_wdf_en ? w_sel_data : '0;
    assign bus.wdf_mask_din = w_wdf_en ? w_sel_mask : '0;
    assign bus.busy         = (|w_req) || (r_state != ARB && !rst);
endmodule
